arm_mul_unit: RTL and testbench
===============================

# arm_mul_unit

Iterative multiply unit for the ARM core. It adds MUL, MLA, UMULL and SMULL support beside the existing single-cycle ALU, and the operand width is a parameter. The controller asserts a start/busy/done handshake, and the unit computes a product with a radix-2 shift-add algorithm at one bit per cycle. Results and N/Z flags are returned for register write-back and the CPSR flag registers.

## Interface
- WIDTH, 32, operand width in bits; legal when ≥ 2.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  2  operation: 00 MUL, 01 MLA, 10 UMULL, 11 SMULL.
- a, b  in  WIDTH  multiplicand and multiplier (Rm, Rs).
- acc  in  WIDTH  accumulate operand (Rn), used only by MLA.
- busy  out  1  high in CALC and FINISH.
- done  out  1  one-cycle pulse; results valid in that cycle.
- result_lo  out  WIDTH  low half / single-width result.
- result_hi  out  WIDTH  high half; 0 for MUL/MLA.
- flags  out  2  {N, Z}.

## Operation
- States: IDLE, CALC, FINISH, DONE.
  - IDLE/DONE --start--> CALC: latch a, b, acc, mode; clear the 2·WIDTH partial product; count = 0.
  - CALC: one iteration per cycle. If the multiplier LSB is 1, add the multiplicand (shifted into the partial-product high half). Then shift right. Increment count. count == WIDTH−1 → FINISH.
  - FINISH: apply the sign fix and accumulate; register results and flags; → DONE.
  - DONE: done = 1. With start → CALC; otherwise → IDLE.
- SMULL: operands are converted to magnitudes at capture. The product sign is a[W−1]^b[W−1], and the 2·WIDTH result is two's-complement negated in FINISH if negative. MUL, MLA and UMULL treat operands as unsigned; the low half is identical for signed operands.
- MLA: result_lo = (a·b + acc) mod 2^WIDTH. The carry-out is discarded.
- MUL/MLA: result_hi = 0. N = result_lo[W−1]; Z = (result_lo == 0).
- UMULL/SMULL: {result_hi, result_lo} is the full 2·WIDTH product. N = result_hi[W−1]; Z = (all 2·WIDTH bits == 0).
- C and V are not produced. The controller leaves them unchanged (FlagW = 10 for multiplies).
- result_lo, result_hi and flags hold their values from FINISH until the next FINISH. They are not cleared on start.
- start while busy is ignored. There is no queueing, and inputs need not stay stable after the accepting edge.
- Iteration counter width: $clog2(WIDTH)+1.

## Timing
- Reset: state IDLE, busy = 0, done = 0, result_lo = 0, result_hi = 0, flags = 00, counter = 0.
- If start is sampled at edge E:
  - busy is high for cycles after edges E … E+WIDTH.
  - done is high only in the cycle after edge E+WIDTH+1.
  - Latency is WIDTH+1 edges; WIDTH = 32 gives 33.
- Back-to-back: start held high in the DONE cycle launches the next operation with no idle cycle. Throughput is one result per WIDTH+1 cycles.
- Reset asserted during any state takes priority at that edge. The operation is aborted, done never pulses for it, and all outputs return to reset values.
- Reset and start in the same cycle: reset wins and start is dropped.
- Operands with a[W−1] = 1 (e.g. the most-negative value) in SMULL: the magnitude is computed in WIDTH+1 bits so that −2^(W−1) is exact.

## Structure
- Shared package arm_pkg:
  - mul_mode_t enum: MUL_OP = 2'b00, MLA_OP, UMULL_OP, SMULL_OP.
  - mul_state_t enum: IDLE, CALC, FINISH, DONE.
  - Decoder constants for the multiply encoding (Instr[7:4] = 1001, Instr[27:24] = 0000).
- One module. FSM, counter and shift-add datapath are tightly coupled, so no sub-module is warranted. Output registers reuse the existing flopenr/flopr with a synchronous-reset variant.

## Test plan
- WIDTH=32, MUL a=7 b=6 → done exactly 33 edges after the start edge; result_lo=0x0000002A, result_hi=0, flags=00; busy low in the done cycle.
- MLA a=0xFFFFFFFF b=2 acc=3 → result_lo=0x00000001, result_hi=0, flags=00.
- UMULL a=b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=10. Back-to-back SMULL with start held in DONE:
  - a=0xFFFFFFFE (−2), b=3 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, flags=10; done 33 edges later.
  - a=0x80000000, b=0x80000000 → result_hi=0x40000000, result_lo=0, flags=00.
  - a=0, b=0x12345678 → all result bits 0, flags=01.
- start pulsed during CALC → ignored, single done. Reset asserted at CALC iteration 10 → next cycle busy=0, outputs zero, no done pulse; a new start afterwards completes normally.
- WIDTH=8 instance, UMULL a=b=0xFF → result_hi=0xFE, result_lo=0x01, done 9 edges after start; SMULL a=0x80 b=0xFF → result_hi=0x00, result_lo=0x80.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core multiply unit and its decoder.
package arm_pkg;

  typedef enum logic [1:0] {
    MUL_OP   = 2'b00,
    MLA_OP   = 2'b01,
    UMULL_OP = 2'b10,
    SMULL_OP = 2'b11
  } mul_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH,
    DONE
  } mul_state_t;

  // Multiply encoding: Instr[7:4] = 1001 with Instr[27:24] = 0000.
  localparam logic [3:0] MUL_FUNCT_BITS = 4'b1001;
  localparam logic [3:0] MUL_OPC_BITS   = 4'b0000;

  function automatic logic is_mul_instr(input logic [31:0] instr);
    return (instr[7:4] == MUL_FUNCT_BITS) && (instr[27:24] == MUL_OPC_BITS);
  endfunction

endpackage

// File: rtl/arm_mul_unit_if.sv
// Start/busy/done handshake and operand/result bus of the multiply unit.
interface arm_mul_unit_if
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  mul_mode_t        mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       flags;

  // Controller side.
  modport master (
    output start, mode, a, b, acc,
    input  busy, done, result_lo, result_hi, flags
  );

  // Multiply unit side.
  modport slave (
    input  start, mode, a, b, acc,
    output busy, done, result_lo, result_hi, flags
  );

endinterface

// File: rtl/arm_mul_unit.sv
// Iterative radix-2 shift-add multiplier: MUL, MLA, UMULL, SMULL, one bit per cycle.
module arm_mul_unit
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  arm_mul_unit_if.slave bus
);

  localparam int unsigned CntW  = $clog2(WIDTH) + 1;
  localparam int unsigned ExtW  = WIDTH + 1;
  localparam int unsigned ProdW = 2 * WIDTH;

  mul_state_t        state_q;
  mul_mode_t         mode_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH:0]    mcand_q;
  logic [WIDTH:0]    mplier_q;
  logic [ProdW-1:0]  prod_q;
  logic [WIDTH-1:0]  acc_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  res_lo_q;
  logic [WIDTH-1:0]  res_hi_q;
  logic [1:0]        flags_q;

  logic              smull;
  logic [WIDTH:0]    a_ext;
  logic [WIDTH:0]    b_ext;
  logic [WIDTH:0]    a_mag;
  logic [WIDTH:0]    b_mag;
  logic [WIDTH:0]    sum;
  logic [ProdW-1:0]  full;
  logic [WIDTH-1:0]  fin_lo;
  logic [WIDTH-1:0]  fin_hi;
  logic [1:0]        fin_flags;

  // Operand magnitudes at capture, one shift-add step, and the FINISH result.
  always_comb begin
    smull = (bus.mode == SMULL_OP);
    // Sign-extend only for SMULL; W+1 bits keep the most-negative value exact.
    a_ext = {smull & bus.a[WIDTH-1], bus.a};
    b_ext = {smull & bus.b[WIDTH-1], bus.b};
    a_mag = a_ext[WIDTH] ? (~a_ext + ExtW'(1)) : a_ext;
    b_mag = b_ext[WIDTH] ? (~b_ext + ExtW'(1)) : b_ext;

    // Add into the high half; the carry becomes the new top bit after the shift.
    sum = {1'b0, prod_q[ProdW-1:WIDTH]} + (mplier_q[0] ? mcand_q : '0);

    full = neg_q ? (~prod_q + ProdW'(1)) : prod_q;
    fin_lo = full[WIDTH-1:0];
    if (mode_q == MLA_OP) begin
      fin_lo = full[WIDTH-1:0] + acc_q;
    end
    fin_hi = mode_q[1] ? full[ProdW-1:WIDTH] : '0;
    if (mode_q[1]) begin
      fin_flags = {fin_hi[WIDTH-1], (full == '0)};
    end else begin
      fin_flags = {fin_lo[WIDTH-1], (fin_lo == '0)};
    end
  end

  // Controller FSM with the datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MUL_OP;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            mode_q   <= bus.mode;
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= bus.acc;
            neg_q    <= smull & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            prod_q   <= '0;
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          prod_q   <= {sum, prod_q[WIDTH-1:1]};
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          res_lo_q <= fin_lo;
          res_hi_q <= fin_hi;
          flags_q  <= fin_flags;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_arm_mul_unit.sv
// Bench for arm_mul_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_arm_mul_unit;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  arm_mul_unit_if #(.WIDTH(32)) bus32 ();
  arm_mul_unit_if #(.WIDTH(8))  bus8 ();

  arm_mul_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  arm_mul_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit machine.
  function automatic void model(input int w, input logic [1:0] m, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] acc,
                                output logic [63:0] lo, output logic [63:0] hi,
                                output logic [1:0] fl);
    logic [63:0] mask;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
    sb = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
    case (m)
      2'b00:   p = a * b;
      2'b01:   p = a * b + acc;
      2'b10:   p = a * b;
      default: p = sa * sb;
    endcase
    lo = p & mask;
    hi = (m[1]) ? ((p >> w) & mask) : 64'd0;
    if (m[1]) fl = {hi[w-1], (lo == 0) && (hi == 0)};
    else      fl = {lo[w-1], lo == 0};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; start is sampled at the next posedge, then inputs are scrambled.
  task automatic go32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] acc);
    bus32.mode = mul_mode_t'(m); bus32.a = a; bus32.b = b; bus32.acc = acc;
    bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    bus32.mode = mul_mode_t'($urandom_range(3));
    bus32.a = $urandom; bus32.b = $urandom; bus32.acc = $urandom;
  endtask

  // Counts edges after the start edge until done; returns at the done-cycle negedge.
  task automatic wait32(input string tag, input int n0);
    int n = n0;
    while (1) begin
      @(negedge clk);
      if (n == n0) check({tag, "_busy_calc"}, bus32.busy, 1);
      if (bus32.done || n > 60) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_done"}, bus32.busy, 0);
  endtask

  task automatic res32(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                       input logic [1:0] fl);
    check({tag, "_lo"}, bus32.result_lo, lo);
    check({tag, "_hi"}, bus32.result_hi, hi);
    check({tag, "_flags"}, bus32.flags, fl);
  endtask

  task automatic op32(input string tag, input logic [1:0] m, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] acc);
    logic [63:0] lo, hi;
    logic [1:0]  fl;
    model(32, m, a, b, acc, lo, hi, fl);
    go32(m, a, b, acc);
    wait32(tag, 0);
    res32(tag, lo[31:0], hi[31:0], fl);
  endtask

  task automatic go8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] acc);
    bus8.mode = mul_mode_t'(m); bus8.a = a; bus8.b = b; bus8.acc = acc;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.acc = 8'($urandom);
  endtask

  task automatic op8(input string tag, input logic [1:0] m, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] acc, input logic use_model,
                     input logic [7:0] lo_c, input logic [7:0] hi_c);
    logic [63:0] lo, hi;
    logic [1:0]  fl;
    int          n = 0;
    model(8, m, a, b, acc, lo, hi, fl);
    if (!use_model) begin
      lo = lo_c; hi = hi_c;
    end
    go8(m, a, b, acc);
    while (1) begin
      @(negedge clk);
      if (bus8.done || n > 30) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_lo"}, bus8.result_lo, lo);
    check({tag, "_hi"}, bus8.result_hi, hi);
    if (use_model) check({tag, "_flags"}, bus8.flags, fl);
  endtask

  initial begin
    bus32.start = 1'b0; bus32.mode = MUL_OP; bus32.a = '0; bus32.b = '0; bus32.acc = '0;
    bus8.start = 1'b0;  bus8.mode = MUL_OP;  bus8.a = '0;  bus8.b = '0;  bus8.acc = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus32.busy, 0);
    check("rst_done", bus32.done, 0);
    res32("rst", 32'h0, 32'h0, 2'b00);
    check("rst8_lo", bus8.result_lo, 0);
    check("rst8_busy", bus8.busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    go32(2'b00, 32'd7, 32'd6, 32'd0);
    wait32("mul", 0);
    res32("mul", 32'h0000_002A, 32'h0, 2'b00);
    @(negedge clk);
    check("mul_done_pulse", bus32.done, 0);

    go32(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd3);
    wait32("mla", 0);
    res32("mla", 32'h0000_0001, 32'h0, 2'b00);
    @(negedge clk);

    go32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    wait32("umull", 0);
    res32("umull", 32'h0000_0001, 32'hFFFF_FFFE, 2'b10);
    // Back-to-back SMULL: start held in each DONE cycle.
    go32(2'b11, 32'hFFFF_FFFE, 32'd3, 32'd0);
    wait32("smull_neg", 0);
    res32("smull_neg", 32'hFFFF_FFFA, 32'hFFFF_FFFF, 2'b10);
    go32(2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0);
    wait32("smull_min", 0);
    res32("smull_min", 32'h0, 32'h4000_0000, 2'b00);
    go32(2'b11, 32'h0, 32'h1234_5678, 32'd0);
    wait32("smull_zero", 0);
    res32("smull_zero", 32'h0, 32'h0, 2'b01);
    @(negedge clk);
    check("b2b_done_low", bus32.done, 0);

    // Start pulsed during CALC is ignored; results hold until the next FINISH.
    op32("hold_pre", 2'b00, 32'd5, 32'd9, 32'd0);
    go32(2'b00, 32'd3, 32'd4, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hold_lo", bus32.result_lo, 45);
    bus32.start = 1'b1; bus32.mode = UMULL_OP; bus32.a = 32'hFFFF_FFFF; bus32.b = 32'd7;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    wait32("ignore", 6);
    res32("ignore", 32'd12, 32'd0, 2'b00);
    repeat (3) @(negedge clk);
    check("ignore_no_requeue", bus32.busy | bus32.done, 0);

    // Reset at CALC iteration 10, with start asserted in the same cycle.
    go32(2'b10, 32'hFFFF_FFFF, 32'd3, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus32.busy, 0);
    check("abort_done", bus32.done, 0);
    res32("abort", 32'h0, 32'h0, 2'b00);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus32.done || bus32.busy) seen++;
      end
      check("abort_quiet", seen, 0);
    end
    op32("after_abort", 2'b11, 32'hFFFF_FFF9, 32'd100, 32'd0);

    // Randomized operations, with occasional idle gaps.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(3));
      if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(negedge clk);
      op32($sformatf("rnd32_%0d", i), m, pick32(), pick32(), $urandom);
    end

    // WIDTH=8 instance.
    @(negedge clk);
    op8("w8_umull", 2'b10, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h01, 8'hFE);
    op8("w8_smull", 2'b11, 8'h80, 8'hFF, 8'h00, 1'b0, 8'h80, 8'h00);
    for (int i = 0; i < 16; i++) begin
      op8($sformatf("rnd8_%0d", i), 2'($urandom_range(3)), 8'($urandom), 8'($urandom),
          8'($urandom), 1'b1, 8'h00, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
